// File: rtl/booth_pkg.sv
// Shared types and default sizing for the Booth multiplier issue/collect stage.
package booth_pkg;

  localparam int WIDTH_DEF   = 4;
  localparam int DEPTH_DEF   = 4;
  localparam int TIMEOUT_DEF = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    GUARD  = 3'd2,
    WAIT   = 3'd3,
    RESULT = 3'd4
  } state_t;

endpackage

// File: rtl/booth_op_fifo.sv
// Synchronous FIFO of {q,m} operand pairs with occupancy count; head is shown combinationally.
module booth_op_fifo
  import booth_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wr_q_i,
  input  logic [WIDTH-1:0]         wr_m_i,
  output logic [WIDTH-1:0]         rd_q_o,
  output logic [WIDTH-1:0]         rd_m_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [2*WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q;
  logic [AW-1:0]      rd_ptr_q;
  logic [AW:0]        count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= {wr_q_i, wr_m_i};
  end

  assign {rd_q_o, rd_m_o} = mem_q[rd_ptr_q];
  assign count_o          = count_q;

endmodule

// File: rtl/booth_issue_ctrl.sv
// Issues queued operand pairs to the Booth multiplier one at a time and returns products downstream.
// Define BOOTH_TIMEOUT_EN to abort a multiplication that never signals fin.
module booth_issue_ctrl
  import booth_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int DEPTH   = DEPTH_DEF
`ifdef BOOTH_TIMEOUT_EN
  , parameter int TIMEOUT = TIMEOUT_DEF
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_q,
  input  logic [WIDTH-1:0]       in_m,
  output logic                   m_start,
  output logic [WIDTH-1:0]       m_q,
  output logic [WIDTH-1:0]       m_m,
  input  logic                   m_fin,
  input  logic [2*WIDTH-1:0]     m_prod,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*WIDTH-1:0]     out_prod,
  output logic                   out_err,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = 2 * WIDTH;

  state_t           state_q, state_d;
  logic             m_start_q, m_start_d;
  logic [WIDTH-1:0] op_q_q, op_q_d;
  logic [WIDTH-1:0] op_m_q, op_m_d;
  logic             out_valid_q, out_valid_d;
  logic [PW-1:0]    out_prod_q, out_prod_d;
  logic             push_s, pop_s;
  logic [WIDTH-1:0] head_q_s, head_m_s;
`ifdef BOOTH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             out_err_q, out_err_d;
`endif

  assign in_ready = (count < CW'(DEPTH)) && !reset;
  assign push_s   = in_valid && in_ready;

  booth_op_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wr_q_i  (in_q),
    .wr_m_i  (in_m),
    .rd_q_o  (head_q_s),
    .rd_m_o  (head_m_s),
    .count_o (count)
  );

  always_comb begin
    state_d     = state_q;
    m_start_d   = 1'b0;
    op_q_d      = op_q_q;
    op_m_d      = op_m_q;
    out_valid_d = out_valid_q;
    out_prod_d  = out_prod_q;
    pop_s       = 1'b0;
`ifdef BOOTH_TIMEOUT_EN
    tmo_d       = tmo_q;
    out_err_d   = out_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (count != {CW{1'b0}}) begin
          pop_s     = 1'b1;
          op_q_d    = head_q_s;
          op_m_d    = head_m_s;
          m_start_d = 1'b1;
          state_d   = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: state_d = GUARD;
      // fin may still be high from the previous operation here, so it is not looked at.
      GUARD: begin
        state_d = WAIT;
`ifdef BOOTH_TIMEOUT_EN
        tmo_d   = {TW{1'b0}};
`endif
      end
      WAIT: begin
        if (m_fin) begin
          out_prod_d  = m_prod;
          out_valid_d = 1'b1;
          state_d     = RESULT;
        end
`ifdef BOOTH_TIMEOUT_EN
        else if (tmo_q == TW'(TIMEOUT - 1)) begin
          out_prod_d  = {PW{1'b0}};
          out_valid_d = 1'b1;
          out_err_d   = 1'b1;
          state_d     = RESULT;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
`else
        else begin
          state_d = WAIT;
        end
`endif
      end
      RESULT: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
`ifdef BOOTH_TIMEOUT_EN
          out_err_d   = 1'b0;
`endif
        end else begin
          state_d = RESULT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      m_start_q   <= 1'b0;
      op_q_q      <= {WIDTH{1'b0}};
      op_m_q      <= {WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      out_prod_q  <= {PW{1'b0}};
`ifdef BOOTH_TIMEOUT_EN
      tmo_q       <= {TW{1'b0}};
      out_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      m_start_q   <= m_start_d;
      op_q_q      <= op_q_d;
      op_m_q      <= op_m_d;
      out_valid_q <= out_valid_d;
      out_prod_q  <= out_prod_d;
`ifdef BOOTH_TIMEOUT_EN
      tmo_q       <= tmo_d;
      out_err_q   <= out_err_d;
`endif
    end
  end

  assign m_start   = m_start_q;
  assign m_q       = op_q_q;
  assign m_m       = op_m_q;
  assign out_valid = out_valid_q;
  assign out_prod  = out_prod_q;
  assign busy      = (state_q != IDLE) || (count != {CW{1'b0}});
`ifdef BOOTH_TIMEOUT_EN
  assign out_err   = out_err_q;
`else
  assign out_err   = 1'b0;
`endif

endmodule
